// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and defaults for the async-FIFO read-side packer.
package fifo_rd_packer_pkg;

   typedef enum logic {
      StFill = 1'b0,
      StOut  = 1'b1
   } state_e;

   localparam int unsigned DefDsize = 8;
   localparam int unsigned DefAsize = 4;
   localparam int unsigned DefPack  = 4;
   localparam int unsigned DefCntw  = 16;

   // Lane index width; never narrower than one bit.
   function automatic int unsigned lane_w(int unsigned pack);
      return (pack > 2) ? $clog2(pack) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries into lane-packed words and streams them out; flush emits a
// trailing partial word tagged with keep/last.
module fifo_rd_packer
   import fifo_rd_packer_pkg::*;
#(
   parameter int unsigned DSIZE = DefDsize,
   parameter int unsigned PACK  = DefPack,
   parameter int unsigned CNTW  = DefCntw
) (
   input  logic                    rclk,
   input  logic                    rrst_n,
   input  logic                    rempty,
   input  logic [DSIZE-1:0]        rdata,
   output logic                    rinc,
   input  logic                    flush,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DSIZE*PACK-1:0]   m_data,
   output logic [PACK-1:0]         m_keep,
   output logic                    m_last,
   output logic                    flush_done,
   output logic [CNTW-1:0]         word_cnt
);

   localparam int unsigned     LANEW    = lane_w(PACK);
   localparam logic [LANEW-1:0] LastLane = LANEW'(PACK - 1);

   state_e           state;
   logic [LANEW-1:0] lane;
   logic             flush_pend;

   // Never pop while a word is held, so backpressure stalls the FIFO.
   assign rinc = rrst_n & (state == StFill) & ~rempty;

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         state      <= StFill;
         lane       <= '0;
         flush_pend <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_keep     <= '0;
         m_last     <= 1'b0;
         flush_done <= 1'b0;
         word_cnt   <= '0;
      end else begin
         flush_done <= 1'b0;
         if (flush) flush_pend <= 1'b1;
         unique case (state)
            StFill: begin
               if (rinc) begin
                  for (int i = 0; i < PACK; i++) begin
                     if (lane == LANEW'(i)) begin
                        m_data[i*DSIZE +: DSIZE] <= rdata;
                        m_keep[i]                <= 1'b1;
                     end
                  end
                  if (lane == LastLane) begin
                     lane    <= '0;
                     m_valid <= 1'b1;
                     m_keep  <= '1;
                     m_last  <= 1'b0;
                     state   <= StOut;
                  end else begin
                     lane <= lane + 1'b1;
                  end
               end else if (flush_pend && lane != '0) begin
                  // Drained with a partial word: unfilled lanes are already zero.
                  lane    <= '0;
                  m_valid <= 1'b1;
                  m_last  <= 1'b1;
                  state   <= StOut;
               end else if (flush_pend) begin
                  flush_pend <= 1'b0;
                  flush_done <= 1'b1;
               end
            end
            StOut: begin
               if (m_ready) begin
                  m_valid  <= 1'b0;
                  m_data   <= '0;
                  m_keep   <= '0;
                  m_last   <= 1'b0;
                  word_cnt <= word_cnt + 1'b1;
                  state    <= StFill;
                  if (m_last) begin
                     flush_pend <= 1'b0;
                     flush_done <= 1'b1;
                  end
               end
            end
            default: state <= StFill;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO and word-level reference model,
// directed scenario table, hand sequences and randomized traffic.
module tb_fifo_rd_packer;

   localparam int PACK  = 4;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   typedef struct {
      int          n;
      logic [7:0]  b[8];
      bit          fl;
      int          nw;
      word_t       w[2];
      int          ndone;
   } scen_t;

   logic        rclk = 1'b0;
   logic        rrst_n = 1'b0;
   logic        rempty = 1'b1;
   logic [7:0]  rdata = 8'h00;
   logic        rinc;
   logic        flush = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_last;
   logic        flush_done;
   logic [15:0] word_cnt;

   fifo_rd_packer #(.DSIZE(8), .PACK(PACK), .CNTW(16)) dut (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .rempty     (rempty),
      .rdata      (rdata),
      .rinc       (rinc),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_keep     (m_keep),
      .m_last     (m_last),
      .flush_done (flush_done),
      .word_cnt   (word_cnt)
   );

   always #20 rclk = ~rclk;

   logic [7:0] fifo_q[$];
   logic [7:0] cur_q[$];
   word_t      acc_q[$];

   // Reference model state: bytes gathered so far, word on offer, pending flush.
   bit          ref_hold;
   word_t       ref_word;
   bit          ref_fpend;
   bit          ref_done;
   logic [15:0] ref_cnt;

   int nvec = 0;
   int nfail = 0;
   int pops = 0;
   int done_cnt = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic word_t pack_cur(bit last);
      word_t w;
      w = '0;
      foreach (cur_q[i]) begin
         w.data[i*8 +: 8] = cur_q[i];
         w.keep[i]        = 1'b1;
      end
      w.last = last;
      return w;
   endfunction

   task automatic push(logic [7:0] b);
      if (fifo_q.size() < DEPTH) fifo_q.push_back(b);
   endtask

   task automatic step(bit rst_v, bit flush_v, bit ready_v);
      bit exp_rinc;
      bit fp_old;
      bit act_rinc;
      @(negedge rclk);
      rrst_n  = rst_v;
      flush   = flush_v;
      m_ready = ready_v;
      rempty  = (fifo_q.size() == 0);
      rdata   = rempty ? 8'h00 : fifo_q[0];
      #1;
      act_rinc = rinc;
      if (m_valid && m_ready && rrst_n) acc_q.push_back({m_data, m_keep, m_last});
      ref_done = 1'b0;
      if (!rst_v) begin
         exp_rinc  = 1'b0;
         ref_hold  = 1'b0;
         ref_fpend = 1'b0;
         ref_cnt   = '0;
         cur_q.delete();
      end else begin
         exp_rinc = !ref_hold && !rempty;
         fp_old   = ref_fpend;
         if (ref_hold) begin
            if (ready_v) begin
               ref_hold = 1'b0;
               ref_cnt++;
               if (ref_word.last) begin
                  ref_fpend = 1'b0;
                  ref_done  = 1'b1;
               end
            end
         end else if (exp_rinc) begin
            cur_q.push_back(fifo_q[0]);
            if (cur_q.size() == PACK) begin
               ref_word = pack_cur(1'b0);
               ref_hold = 1'b1;
               cur_q.delete();
            end
         end else if (fp_old && cur_q.size() > 0) begin
            ref_word = pack_cur(1'b1);
            ref_hold = 1'b1;
            cur_q.delete();
         end else if (fp_old) begin
            ref_fpend = 1'b0;
            ref_done  = 1'b1;
         end
         if (flush_v && !fp_old) ref_fpend = 1'b1;
      end
      check("rinc", act_rinc, exp_rinc);
      if (act_rinc && fifo_q.size() > 0) begin
         pops++;
         void'(fifo_q.pop_front());
      end
      @(posedge rclk);
      #1;
      check("m_valid", m_valid, ref_hold);
      check("flush_done", flush_done, ref_done);
      check("word_cnt", word_cnt, ref_cnt);
      if (ref_hold) begin
         check("m_data", m_data, ref_word.data);
         check("m_keep", m_keep, ref_word.keep);
         check("m_last", m_last, ref_word.last);
      end
      if (flush_done) done_cnt++;
   endtask

   task automatic do_reset();
      fifo_q.delete();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
   endtask

   scen_t tab[5];

   initial begin
      tab[0] = '{8, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 1'b0, 2,
                 '{'{32'h04030201, 4'hF, 1'b0}, '{32'h08070605, 4'hF, 1'b0}}, 0};
      tab[1] = '{3, '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1,
                 '{'{32'h00CCBBAA, 4'b0111, 1'b1}, '{32'h0, 4'h0, 1'b0}}, 1};
      tab[2] = '{4, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1,
                 '{'{32'h44332211, 4'hF, 1'b0}, '{32'h0, 4'h0, 1'b0}}, 1};
      tab[3] = '{0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 0,
                 '{'{32'h0, 4'h0, 1'b0}, '{32'h0, 4'h0, 1'b0}}, 1};
      tab[4] = '{5, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00}, 1'b1, 2,
                 '{'{32'h04030201, 4'hF, 1'b0}, '{32'h00000005, 4'b0001, 1'b1}}, 1};

      // Reset held with a non-empty FIFO: no pops, outputs cleared.
      push(8'h5A); push(8'h5B); push(8'h5C);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("reset m_data", m_data, 32'h0);
      check("reset m_keep", m_keep, 4'h0);

      foreach (tab[t]) begin
         do_reset();
         for (int k = 0; k < tab[t].n; k++) push(tab[t].b[k]);
         acc_q.delete();
         done_cnt = 0;
         step(1'b1, tab[t].fl, 1'b1);
         repeat (20) step(1'b1, 1'b0, 1'b1);
         check("scen word count", acc_q.size(), tab[t].nw);
         for (int k = 0; k < tab[t].nw && k < acc_q.size(); k++) begin
            check("scen word data", acc_q[k].data, tab[t].w[k].data);
            check("scen word keep", acc_q[k].keep, tab[t].w[k].keep);
            check("scen word last", acc_q[k].last, tab[t].w[k].last);
         end
         check("scen flush_done count", done_cnt, tab[t].ndone);
      end

      // Backpressure: one word held, exactly four pops, then release in order.
      do_reset();
      for (int k = 0; k < 16; k++) push(8'(8'h10 + k));
      pops = 0;
      repeat (12) step(1'b1, 1'b0, 1'b0);
      check("stall pops", pops, 4);
      check("stall m_valid", m_valid, 1'b1);
      check("stall m_data", m_data, 32'h13121110);
      acc_q.delete();
      repeat (30) step(1'b1, 1'b0, 1'b1);
      check("release word count", acc_q.size(), 4);
      for (int k = 0; k < 4 && k < acc_q.size(); k++)
         check("release word data", acc_q[k].data, 32'h13121110 + k * 32'h04040404);

      // Mid-fill reset discards the partially packed lanes.
      do_reset();
      push(8'hE1); push(8'hE2);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      acc_q.delete();
      repeat (12) step(1'b1, 1'b0, 1'b1);
      check("post-reset word count", acc_q.size(), 1);
      if (acc_q.size() > 0) begin
         check("post-reset data", acc_q[0].data, 32'hA4A3A2A1);
         check("post-reset keep", acc_q[0].keep, 4'hF);
         check("post-reset last", acc_q[0].last, 1'b0);
      end

      // Randomized traffic with varying write rate, flushes, stalls and rare resets.
      do_reset();
      for (int ph = 0; ph < 6; ph++) begin
         int wr_pct;
         wr_pct = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 60 : 95;
         repeat (500) begin
            if ($urandom_range(99) < wr_pct) push(8'($urandom));
            step($urandom_range(399) != 0, $urandom_range(24) == 0, $urandom_range(3) != 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
